// File: rtl/operand_fetch_rf_if.sv
// Bundle between decode/ALU and the operand fetch stage.
// master drives the fetch slot and ALU results; slave returns operands.
interface operand_fetch_rf_if #(
   parameter int LANES  = 2,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int OPC_W  = 4
);
   logic                    stall;
   logic                    in_valid;
   logic [LANES-1:0]        is_immediate;
   logic [LANES*ADDR_W-1:0] addr;
   logic [LANES-1:0]        is_load_in;
   logic [LANES-1:0]        is_store_in;
   logic [LANES*OPC_W-1:0]  opcode_in;
   logic [LANES*DATA_W-1:0] data_in;
   logic [LANES*DATA_W-1:0] alu_result;
   logic [LANES*DATA_W-1:0] value;
   logic [LANES-1:0]        is_load_out;
   logic [LANES*OPC_W-1:0]  opcode_out;
   logic                    out_valid;
   logic                    wb_conflict;

   modport master (
      output stall, in_valid, is_immediate, addr,
      output is_load_in, is_store_in, opcode_in,
      output data_in, alu_result,
      input  value, is_load_out, opcode_out,
      input  out_valid, wb_conflict
   );

   modport slave (
      input  stall, in_valid, is_immediate, addr,
      input  is_load_in, is_store_in, opcode_in,
      input  data_in, alu_result,
      output value, is_load_out, opcode_out,
      output out_valid, wb_conflict
   );
endinterface

// File: rtl/operand_fetch_rf.sv
// Multi-lane operand fetch over an integrated register file; store-tagged
// slots commit their lane's ALU result WB_DELAY non-stalled edges later.
module operand_fetch_rf #(
   parameter int LANES    = 2,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 12,
   parameter int NUM_REGS = 32,
   parameter int OPC_W    = 4,
   parameter int WB_DELAY = 2
) (
   input logic               clk,
   input logic               rst,
   operand_fetch_rf_if.slave bus
);
   localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int LD = WB_DELAY - 1;

   logic [DATA_W-1:0]       regs_q [NUM_REGS];
   logic [DATA_W-1:0]       regs_d [NUM_REGS];
   logic                    hst_q  [LANES][WB_DELAY];
   logic [ADDR_W-1:0]       had_q  [LANES][WB_DELAY];
   logic [ADDR_W-1:0]       rd_a   [LANES];
   logic [ADDR_W-1:0]       wb_a   [LANES];
   logic [LANES-1:0]        cm_v;
   logic [LANES*DATA_W-1:0] value_q, value_d;
   logic [LANES-1:0]        load_q, load_d;
   logic [LANES*OPC_W-1:0]  opc_q, opc_d;
   logic                    valid_q;
   logic                    conf_q, conf_d;

   function automatic logic in_rf(
      input logic [ADDR_W-1:0] a
   );
      return (a != '0) && (int'(a) < NUM_REGS);
   endfunction

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign rd_a[g] = bus.addr[g*ADDR_W +: ADDR_W];
      assign wb_a[g] = had_q[g][LD];
   end

   // Lanes apply in ascending order so the highest index wins a clash.
   always_comb begin
      regs_d = regs_q;
      cm_v   = '0;
      conf_d = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         cm_v[l] = hst_q[l][LD] && in_rf(wb_a[l]);
         if (cm_v[l])
            regs_d[wb_a[l][RW-1:0]] =
               bus.alu_result[l*DATA_W +: DATA_W];
      end
      for (int i = 0; i < LANES; i++)
         for (int j = i + 1; j < LANES; j++)
            if (cm_v[i] && cm_v[j] && wb_a[i] == wb_a[j])
               conf_d = 1'b1;
   end

   // Reads see regs_d, giving write-first forwarding.
   always_comb begin
      value_d = '0;
      load_d  = '0;
      opc_d   = '0;
      for (int l = 0; l < LANES; l++) begin
         if (bus.in_valid) begin
            load_d[l] = bus.is_load_in[l];
            opc_d[l*OPC_W +: OPC_W] =
               bus.opcode_in[l*OPC_W +: OPC_W];
            if (rd_a[l] == '0)
               value_d[l*DATA_W +: DATA_W] =
                  bus.data_in[l*DATA_W +: DATA_W];
            else if (bus.is_immediate[l])
               value_d[l*DATA_W +: DATA_W] = DATA_W'(rd_a[l]);
            else if (in_rf(rd_a[l]))
               value_d[l*DATA_W +: DATA_W] =
                  regs_d[rd_a[l][RW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         load_q  <= '0;
         opc_q   <= '0;
         valid_q <= 1'b0;
         conf_q  <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++)
            regs_q[r] <= '0;
         for (int l = 0; l < LANES; l++)
            for (int k = 0; k < WB_DELAY; k++) begin
               hst_q[l][k] <= 1'b0;
               had_q[l][k] <= '0;
            end
      end else if (!bus.stall) begin
         value_q <= value_d;
         load_q  <= load_d;
         opc_q   <= opc_d;
         valid_q <= bus.in_valid;
         conf_q  <= conf_d;
         regs_q  <= regs_d;
         for (int l = 0; l < LANES; l++) begin
            hst_q[l][0] <= bus.in_valid && bus.is_store_in[l];
            had_q[l][0] <= rd_a[l];
            for (int k = 1; k < WB_DELAY; k++) begin
               hst_q[l][k] <= hst_q[l][k-1];
               had_q[l][k] <= had_q[l][k-1];
            end
         end
      end
   end

   assign bus.value       = value_q;
   assign bus.is_load_out = load_q;
   assign bus.opcode_out  = opc_q;
   assign bus.out_valid   = valid_q;
   assign bus.wb_conflict = conf_q;
endmodule

// File: tb/tb_operand_fetch_rf.sv
// Bench for operand_fetch_rf: directed cases plus randomized traffic
// checked every cycle against a pending-commit list model.
module tb_operand_fetch_rf;
   localparam int L  = 2;
   localparam int DW = 16;
   localparam int AW = 12;
   localparam int NR = 32;
   localparam int OW = 4;
   localparam int WD = 2;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   operand_fetch_rf_if #(
      .LANES(L), .DATA_W(DW), .ADDR_W(AW), .OPC_W(OW)
   ) bus ();

   operand_fetch_rf #(
      .LANES(L), .DATA_W(DW), .ADDR_W(AW),
      .NUM_REGS(NR), .OPC_W(OW), .WB_DELAY(WD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          lane;
      logic [AW-1:0] a;
      int          rem;
   } pend_t;

   pend_t         pq[$];
   logic [DW-1:0] rf [NR];
   logic [DW-1:0] exp_v [L];
   logic [L-1:0]  exp_ld;
   logic [L*OW-1:0] exp_op;
   logic          exp_valid;
   logic          exp_conf;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h @%0t",
                    name, act, exp, $time);
   endtask

   task automatic model_reset();
      foreach (rf[r]) rf[r] = '0;
      pq.delete();
      foreach (exp_v[l]) exp_v[l] = '0;
      exp_ld = '0;
      exp_op = '0;
      exp_valid = 1'b0;
      exp_conf = 1'b0;
   endtask

   // Pending stores count down non-stalled edges; at zero they commit.
   task automatic model_edge();
      int cnt [NR];
      logic [AW-1:0] a;
      foreach (cnt[r]) cnt[r] = 0;
      foreach (pq[i]) pq[i].rem--;
      exp_conf = 1'b0;
      for (int l = 0; l < L; l++)
         foreach (pq[i])
            if (pq[i].lane == l && pq[i].rem == 0 &&
                pq[i].a != 0 && pq[i].a < NR) begin
               rf[pq[i].a] = bus.alu_result[l*DW +: DW];
               cnt[pq[i].a]++;
               if (cnt[pq[i].a] > 1) exp_conf = 1'b1;
            end
      for (int i = pq.size() - 1; i >= 0; i--)
         if (pq[i].rem == 0) pq.delete(i);
      exp_valid = bus.in_valid;
      exp_ld = '0;
      exp_op = '0;
      for (int l = 0; l < L; l++) begin
         a = bus.addr[l*AW +: AW];
         exp_v[l] = '0;
         if (bus.in_valid) begin
            exp_ld[l] = bus.is_load_in[l];
            exp_op[l*OW +: OW] = bus.opcode_in[l*OW +: OW];
            if (a == 0) exp_v[l] = bus.data_in[l*DW +: DW];
            else if (bus.is_immediate[l]) exp_v[l] = {4'b0, a};
            else if (a < NR) exp_v[l] = rf[a];
            else exp_v[l] = '0;
            if (bus.is_store_in[l])
               pq.push_back('{lane: l, a: a, rem: WD});
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else if (!bus.stall) model_edge();
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk("value0", bus.value[0 +: DW], exp_v[0]);
         chk("value1", bus.value[DW +: DW], exp_v[1]);
         chk("is_load_out", bus.is_load_out, exp_ld);
         chk("opcode_out", bus.opcode_out, exp_op);
         chk("out_valid", bus.out_valid, exp_valid);
         chk("wb_conflict", bus.wb_conflict, exp_conf);
      end
   end

   task automatic idle();
      bus.stall = 1'b0;
      bus.in_valid = 1'b0;
      bus.is_immediate = '0;
      bus.addr = '0;
      bus.is_load_in = '0;
      bus.is_store_in = '0;
      bus.opcode_in = '0;
      bus.data_in = '0;
      bus.alu_result = '0;
   endtask

   task automatic lane(int l, logic imm, logic [AW-1:0] a,
                       logic st, logic [DW-1:0] din);
      bus.in_valid = 1'b1;
      bus.is_immediate[l] = imm;
      bus.addr[l*AW +: AW] = a;
      bus.is_store_in[l] = st;
      bus.data_in[l*DW +: DW] = din;
   endtask

   task automatic alu(int l, logic [DW-1:0] v);
      bus.alu_result[l*DW +: DW] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst = 1'b0;
      model_reset();
      idle();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_value", bus.value, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_conflict", bus.wb_conflict, 0);
      chk("rst_opcode", bus.opcode_out, 0);
      chk("rst_load", bus.is_load_out, 0);
      rst = 1'b1;

      idle(); lane(0, 0, 12'd5, 0, 0);
      bus.is_load_in[0] = 1'b1;
      bus.opcode_in[3:0] = 4'hA;
      tick();
      chk("read_r5", bus.value[0 +: DW], 16'h0000);
      chk("valid_lat", bus.out_valid, 1);
      chk("load_pass", bus.is_load_out, 2'b01);
      chk("opc_pass", bus.opcode_out, 8'h0A);

      idle(); lane(0, 0, 12'd0, 0, 16'hBEEF);
      lane(1, 1, 12'hABC, 0, 0);
      tick();
      chk("bypass", bus.value[0 +: DW], 16'hBEEF);
      chk("imm", bus.value[DW +: DW], 16'h0ABC);

      idle(); lane(0, 0, 12'd7, 1, 0);
      tick();
      idle(); alu(0, 16'hDEAD);
      tick();
      chk("bubble_valid", bus.out_valid, 0);
      idle(); alu(0, 16'h1234); lane(1, 0, 12'd7, 0, 0);
      tick();
      chk("fwd_r7", bus.value[DW +: DW], 16'h1234);
      idle(); lane(0, 0, 12'd7, 0, 0);
      tick();
      chk("read_r7", bus.value[0 +: DW], 16'h1234);

      idle(); lane(0, 0, 12'd9, 1, 0); lane(1, 0, 12'd9, 1, 0);
      tick();
      idle();
      tick();
      idle(); alu(0, 16'h1111); alu(1, 16'h2222);
      lane(0, 0, 12'd9, 0, 0);
      tick();
      chk("conf_r9", bus.value[0 +: DW], 16'h2222);
      chk("conf_pulse", bus.wb_conflict, 1);
      idle();
      tick();
      chk("conf_clear", bus.wb_conflict, 0);

      idle(); lane(0, 0, 12'd3, 1, 0);
      lane(1, 0, 12'd0, 0, 16'hCAFE);
      tick();
      idle(); bus.stall = 1'b1; alu(0, 16'h5555);
      lane(1, 1, 12'h111, 0, 0);
      bus.stall = 1'b1;
      repeat (3) begin
         tick();
         chk("stall_hold", bus.value[DW +: DW], 16'hCAFE);
      end
      idle(); alu(0, 16'h6666); lane(1, 0, 12'd3, 0, 0);
      tick();
      chk("stall_nocommit", bus.value[DW +: DW], 16'h0000);
      idle(); alu(0, 16'h7777); lane(1, 0, 12'd3, 0, 0);
      tick();
      chk("stall_commit", bus.value[DW +: DW], 16'h7777);

      idle(); lane(0, 0, 12'd4, 1, 0); alu(0, 16'h4444);
      tick();
      idle(); alu(0, 16'h4444); lane(1, 1, 12'h123, 0, 0);
      tick();
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_value", bus.value, 0);
      idle();
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) begin
         idle(); alu(0, 16'h4444); lane(0, 0, 12'd4, 0, 0);
         tick();
         chk("arst_r4", bus.value[0 +: DW], 16'h0000);
      end

      for (int c = 0; c < 600; c++) begin
         idle();
         bus.stall = ($urandom_range(0, 5) == 0);
         bus.in_valid = ($urandom_range(0, 4) != 0);
         for (int l = 0; l < L; l++) begin
            bus.is_immediate[l] = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
               0: bus.addr[l*AW +: AW] = '0;
               1: bus.addr[l*AW +: AW] = AW'($urandom);
               default:
                  bus.addr[l*AW +: AW] = AW'($urandom_range(1, 40));
            endcase
            bus.is_store_in[l] = ($urandom_range(0, 2) == 0);
            bus.is_load_in[l] = 1'($urandom);
            bus.opcode_in[l*OW +: OW] = OW'($urandom);
            bus.data_in[l*DW +: DW] = DW'($urandom);
            bus.alu_result[l*DW +: DW] = DW'($urandom);
         end
         if ($urandom_range(0, 3) == 0)
            bus.addr[AW +: AW] = bus.addr[0 +: AW];
         tick();
      end

      idle();
      tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
